hazard_control_unit: RTL and testbench

- Sequences the 5-stage pipelined RV32I core from the ID stage. It is the single source of the pipeline-control strobes: PC write enable, IF/ID write enable, ID/EX bubble and the IF/ID and ID/EX flushes.
- It detects load-use hazards on the fields decoded in ID and applies EX-stage branch/jump redirects.
- On an ECALL halt it drains the pipeline and raises `is_halted`.
- It keeps saturating stall and flush counters for performance checks.

---
 rtl/hazard_control_unit_pkg.sv | 34 +++
 rtl/hazard_control_unit_hazard_detect.sv | 23 ++
 rtl/hazard_control_unit.sv | 103 ++++++++++
 tb/tb_hazard_control_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared opcodes, FSM state encoding and source-usage decode for the hazard control unit.
package hazard_control_unit_pkg;

    localparam int unsigned kOpcodeWidth  = 7;
    localparam int unsigned kRegAddrWidth = 5;

    localparam logic [kOpcodeWidth-1:0] kOpLoad   = 7'b0000011;
    localparam logic [kOpcodeWidth-1:0] kOpStore  = 7'b0100011;
    localparam logic [kOpcodeWidth-1:0] kOpBranch = 7'b1100011;
    localparam logic [kOpcodeWidth-1:0] kOpJal    = 7'b1101111;
    localparam logic [kOpcodeWidth-1:0] kOpJalr   = 7'b1100111;
    localparam logic [kOpcodeWidth-1:0] kOpLui    = 7'b0110111;
    localparam logic [kOpcodeWidth-1:0] kOpAuipc  = 7'b0010111;
    localparam logic [kOpcodeWidth-1:0] kOpRType  = 7'b0110011;
    localparam logic [kOpcodeWidth-1:0] kOpIType  = 7'b0010011;
    localparam logic [kOpcodeWidth-1:0] kOpSystem = 7'b1110011;

    typedef enum logic [1:0] {
        kHcuRun    = 2'd0,
        kHcuDrain  = 2'd1,
        kHcuHalted = 2'd2
    } hcu_state_e;

    // Every format except U-type and JAL reads rs1.
    function automatic logic uses_rs1(input logic [kOpcodeWidth-1:0] op);
        return !((op == kOpLui) || (op == kOpAuipc) || (op == kOpJal));
    endfunction

    // Only R-type, stores and branches read rs2.
    function automatic logic uses_rs2(input logic [kOpcodeWidth-1:0] op);
        return (op == kOpRType) || (op == kOpStore) || (op == kOpBranch);
    endfunction

endpackage

// File: rtl/hazard_control_unit_hazard_detect.sv
// Combinational load-use hazard check of the ID sources against a load in EX.
module hazard_detect
    import hazard_control_unit_pkg::*;
(
    input  logic [kOpcodeWidth-1:0]  opcode,
    input  logic [kRegAddrWidth-1:0] rs1,
    input  logic [kRegAddrWidth-1:0] rs2,
    input  logic                     ex_mem_read,
    input  logic [kRegAddrWidth-1:0] ex_rd,
    output logic                     hazard
);

    logic rs1_match;
    logic rs2_match;

    // x0 is never written, so a load targeting it cannot create a dependency.
    always_comb begin
        rs1_match = uses_rs1(opcode) && (rs1 == ex_rd);
        rs2_match = uses_rs2(opcode) && (rs2 == ex_rd);
        hazard    = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline-control strobes, halt drain sequencing and stall/flush counters for the ID stage.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned kDrainCycles  = 3,
    parameter int unsigned kCounterWidth = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [kOpcodeWidth-1:0]  id_opcode,
    input  logic [kRegAddrWidth-1:0] id_rs1,
    input  logic [kRegAddrWidth-1:0] id_rs2,
    input  logic                     id_is_halt,
    input  logic                     ex_mem_read,
    input  logic [kRegAddrWidth-1:0] ex_rd,
    input  logic                     ex_pc_redirect,
    output logic                     pc_write,
    output logic                     if_id_write,
    output logic                     id_ex_bubble,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
    output logic                     is_halted,
    output logic [kCounterWidth-1:0] stall_count,
    output logic [kCounterWidth-1:0] flush_count
);

    localparam int unsigned DrainW = (kDrainCycles < 2) ? 1 : $clog2(kDrainCycles + 1);

    hcu_state_e        state;
    logic [DrainW-1:0] drain_cnt;
    logic              hazard;

    hazard_detect u_hazard_detect (
        .opcode      (id_opcode),
        .rs1         (id_rs1),
        .rs2         (id_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    // State, drain countdown, halt flag and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= kHcuRun;
            drain_cnt   <= '0;
            is_halted   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            case (state)
                kHcuRun: begin
                    if (ex_pc_redirect) begin
                        if (flush_count != '1) flush_count <= flush_count + kCounterWidth'(1);
                    end else if (hazard) begin
                        if (stall_count != '1) stall_count <= stall_count + kCounterWidth'(1);
                    end else if (id_is_halt) begin
                        state     <= kHcuDrain;
                        drain_cnt <= DrainW'(kDrainCycles);
                    end
                end
                kHcuDrain: begin
                    if (drain_cnt <= DrainW'(1)) begin
                        state     <= kHcuHalted;
                        drain_cnt <= '0;
                        is_halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DrainW'(1);
                    end
                end
                kHcuHalted: begin
                    is_halted <= 1'b1;
                end
                default: begin
                    state <= kHcuRun;
                end
            endcase
        end
    end

    // Same-cycle strobes; anything other than RUN out of reset freezes the front end behind bubbles.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (!reset && (state == kHcuRun)) begin
            if (ex_pc_redirect) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_bubble = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (!hazard) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_bubble = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: stalls, redirects, halt drain, reset abort, saturation.
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    // Strobe vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush}
    localparam logic [4:0] kStrStall    = 5'b00100;
    localparam logic [4:0] kStrNormal   = 5'b11000;
    localparam logic [4:0] kStrRedirect = 5'b11011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_is_halt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_pc_redirect;

    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, is_halted;
    logic [31:0] stall_count, flush_count;
    logic        pc_write4, if_id_write4, id_ex_bubble4, if_id_flush4, id_ex_flush4, is_halted4;
    logic [3:0]  stall_count4, flush_count4;
    logic [4:0]  strobes;

    int checks   = 0;
    int failures = 0;

    assign strobes = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush};

    always #5 clk = ~clk;

    hazard_control_unit dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_halt(id_is_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_pc_redirect(ex_pc_redirect), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .is_halted(is_halted), .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_control_unit #(.kDrainCycles(3), .kCounterWidth(4)) dut4 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_halt(id_is_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_pc_redirect(ex_pc_redirect), .pc_write(pc_write4), .if_id_write(if_id_write4),
        .id_ex_bubble(id_ex_bubble4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .is_halted(is_halted4), .stall_count(stall_count4), .flush_count(flush_count4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic halt, input logic mr, input logic [4:0] rd, input logic redir);
        id_opcode      = op;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_is_halt     = halt;
        ex_mem_read    = mr;
        ex_rd          = rd;
        ex_pc_redirect = redir;
        #1;
    endtask

    task automatic idle();
        drive(kOpIType, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        checks++;
        if (strobes !== kStrStall) begin
            failures++; $display("FAIL reset_strobes got=%b exp=%b", strobes, kStrStall);
        end
        checks++;
        if (is_halted !== 1'b0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
            failures++; $display("FAIL reset_regs halted=%b stall=%0d flush=%0d exp 0/0/0", is_halted, stall_count, flush_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (strobes !== kStrNormal) begin
            failures++; $display("FAIL reset_release_strobes got=%b exp=%b", strobes, kStrNormal);
        end
        tick();
    endtask

    task automatic test_load_use();
        // ADD x6,x5,x7 behind a load of x5
        drive(kOpRType, 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b0);
        checks++;
        if (strobes !== kStrStall) begin
            failures++; $display("FAIL load_use_rs1 got=%b exp=%b", strobes, kStrStall);
        end
        tick();
        checks++;
        if (stall_count !== 32'd1) begin
            failures++; $display("FAIL load_use_count got=%0d exp=1", stall_count);
        end
        // Load has moved on; EX now holds the bubble
        drive(kOpRType, 5'd5, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
        checks++;
        if (strobes !== kStrNormal) begin
            failures++; $display("FAIL load_use_release got=%b exp=%b", strobes, kStrNormal);
        end
        tick();
        // Store data operand depends on the load
        drive(kOpStore, 5'd2, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0);
        checks++;
        if (strobes !== kStrStall) begin
            failures++; $display("FAIL load_use_rs2 got=%b exp=%b", strobes, kStrStall);
        end
        tick();
        checks++;
        if (stall_count !== 32'd2) begin
            failures++; $display("FAIL load_use_rs2_count got=%0d exp=2", stall_count);
        end
    endtask

    task automatic test_no_stall();
        drive(kOpIType, 5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0);
        checks++;
        if (strobes !== kStrNormal) begin
            failures++; $display("FAIL no_stall_x0 got=%b exp=%b", strobes, kStrNormal);
        end
        tick();
        drive(kOpLui, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        checks++;
        if (strobes !== kStrNormal) begin
            failures++; $display("FAIL no_stall_lui got=%b exp=%b", strobes, kStrNormal);
        end
        tick();
        drive(kOpIType, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
        checks++;
        if (strobes !== kStrNormal) begin
            failures++; $display("FAIL no_stall_itype_rs2 got=%b exp=%b", strobes, kStrNormal);
        end
        tick();
        checks++;
        if (stall_count !== 32'd2) begin
            failures++; $display("FAIL no_stall_count got=%0d exp=2", stall_count);
        end
    endtask

    task automatic test_redirect();
        drive(kOpRType, 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b1);
        checks++;
        if (strobes !== kStrRedirect) begin
            failures++; $display("FAIL redirect_over_hazard got=%b exp=%b", strobes, kStrRedirect);
        end
        tick();
        checks++;
        if (flush_count !== 32'd1 || stall_count !== 32'd2) begin
            failures++; $display("FAIL redirect_counts flush=%0d stall=%0d exp 1/2", flush_count, stall_count);
        end
        // Wrong-path halt must not start a drain
        drive(kOpSystem, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        idle();
        checks++;
        if (strobes !== kStrNormal || flush_count !== 32'd2) begin
            failures++; $display("FAIL redirect_halt_ignored strobes=%b flush=%0d exp %b/2", strobes, flush_count, kStrNormal);
        end
    endtask

    task automatic test_halt();
        drive(kOpSystem, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        checks++;
        if (strobes !== kStrNormal) begin
            failures++; $display("FAIL halt_issue got=%b exp=%b", strobes, kStrNormal);
        end
        tick();
        for (int i = 1; i <= 3; i++) begin
            // Redirect asserted during drain must be ignored
            drive(kOpIType, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
            checks++;
            if (strobes !== kStrStall || is_halted !== 1'b0) begin
                failures++; $display("FAIL halt_drain_t%0d strobes=%b halted=%b exp %b/0", i, strobes, is_halted, kStrStall);
            end
            tick();
        end
        idle();
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (is_halted !== 1'b1 || strobes !== kStrStall) begin
                failures++; $display("FAIL halt_held_t%0d halted=%b strobes=%b exp 1/%b", 4 + i, is_halted, strobes, kStrStall);
            end
            tick();
        end
        checks++;
        if (flush_count !== 32'd2 || stall_count !== 32'd2) begin
            failures++; $display("FAIL halt_counts flush=%0d stall=%0d exp 2/2", flush_count, stall_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        drive(kOpSystem, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (strobes !== kStrStall) begin
            failures++; $display("FAIL mid_drain_reset_strobes got=%b exp=%b", strobes, kStrStall);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (strobes !== kStrNormal || is_halted !== 1'b0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
            failures++; $display("FAIL mid_drain_abort strobes=%b halted=%b stall=%0d flush=%0d exp %b/0/0/0",
                                 strobes, is_halted, stall_count, flush_count, kStrNormal);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (is_halted !== 1'b0 || strobes !== kStrNormal) begin
            failures++; $display("FAIL mid_drain_stays_run halted=%b strobes=%b exp 0/%b", is_halted, strobes, kStrNormal);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(kOpBranch, 5'd4, 5'd11, 1'b0, 1'b1, 5'd11, 1'b0);
            tick();
        end
        checks++;
        if (stall_count4 !== 4'd15 || stall_count !== 32'd20) begin
            failures++; $display("FAIL stall_saturate narrow=%0d wide=%0d exp 15/20", stall_count4, stall_count);
        end
        for (int i = 0; i < 20; i++) begin
            drive(kOpIType, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
            tick();
        end
        checks++;
        if (flush_count4 !== 4'd15 || flush_count !== 32'd20) begin
            failures++; $display("FAIL flush_saturate narrow=%0d wide=%0d exp 15/20", flush_count4, flush_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_halt();
        test_reset_mid_drain();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
